// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and zero-register helper for reg_file_sb
package rf_pkg;

  localparam int          XLEN_DEF = 32;
  localparam int          NREG_DEF = 32;
  localparam int unsigned REG_ZERO = 0;

  // True when the zero register is enabled and addr selects it.
  function automatic logic is_zero_reg(input logic zero_en, input logic [31:0] addr);
    return zero_en && (addr == 32'(REG_ZERO));
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits with set/clear priority and effective-busy lookups
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int  NREG     = NREG_DEF,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic [AW-1:0] addr3,
  output logic          busy1,
  output logic          busy2,
  output logic          busy3
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] eff_busy;

  // Set is applied after clear so a new producer issuing on the same edge wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    eff_busy = busy_q;
    if ((BYPASS != 0) && clr_en) eff_busy[clr_addr] = 1'b0;
    if (ZERO_REG != 0) eff_busy[0] = 1'b0;
  end

  assign busy1 = eff_busy[addr1];
  assign busy2 = eff_busy[addr2];
  assign busy3 = eff_busy[addr3];

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2R/1W register file with zero register, write bypass and busy scoreboard
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int  XLEN     = XLEN_DEF,
  parameter int  NREG     = NREG_DEF,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   src1,
  input  logic [AW-1:0]   src2,
  output logic [XLEN-1:0] read1,
  output logic [XLEN-1:0] read2,
  output logic            read1_busy,
  output logic            read2_busy,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_dest,
  input  logic            issue_wr,
  output logic            hazard,
  input  logic            reg_write,
  input  logic [AW-1:0]   dest,
  input  logic [XLEN-1:0] write_data
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] mem_d [NREG];
  logic            wr_en;
  logic            fwd1;
  logic            fwd2;
  logic            dest_busy;
  logic            issue_ok;

  assign wr_en = reg_write && !is_zero_reg(ZERO_REG != 0, 32'(dest));

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[dest] = write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  assign fwd1 = (BYPASS != 0) && wr_en && (dest == src1);
  assign fwd2 = (BYPASS != 0) && wr_en && (dest == src2);

  always_comb begin
    read1 = fwd1 ? write_data : mem_q[src1];
    read2 = fwd2 ? write_data : mem_q[src2];
    if (is_zero_reg(ZERO_REG != 0, 32'(src1))) read1 = '0;
    if (is_zero_reg(ZERO_REG != 0, 32'(src2))) read2 = '0;
  end

  assign hazard   = issue_valid && (read1_busy || read2_busy || (issue_wr && dest_busy));
  assign issue_ok = issue_valid && !hazard && issue_wr;

  rf_scoreboard #(
    .NREG     (NREG),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (reg_write),
    .clr_addr (dest),
    .set_en   (issue_ok),
    .set_addr (issue_dest),
    .addr1    (src1),
    .addr2    (src2),
    .addr3    (issue_dest),
    .busy1    (read1_busy),
    .busy2    (read2_busy),
    .busy3    (dest_busy)
  );

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's 2-read/1-write integer register file.
- Adds:
  - configurable data width and depth
  - optional hardwired zero register
  - write-to-read bypass
  - per-register busy scoreboard
- The decode stage uses the scoreboard to stall RAW/WAW hazards against in-flight multi-cycle writers.
- Sits between decode (read/issue side) and writeback (write side).

Parameters:
XLEN, 32, data width in bits.
NREG, 32, number of architectural registers (power of two, >= 2).
AW, $clog2(NREG), address width (localparam, derived, not overridable).
ZERO_REG, 1, when 1, register 0 reads as 0 and is never written or marked busy.
BYPASS, 1, when 1, same-cycle writeback data and busy-clear are forwarded to read ports.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous active-high reset.
src1  in  AW  read port 1 address.
src2  in  AW  read port 2 address.
read1  out  XLEN  read port 1 data (combinational).
read2  out  XLEN  read port 2 data (combinational).
read1_busy  out  1  src1 has a pending write.
read2_busy  out  1  src2 has a pending write.
issue_valid  in  1  decode requests to issue an instruction.
issue_dest  in  AW  destination of the issuing instruction.
issue_wr  in  1  issuing instruction writes issue_dest (sets busy).
hazard  out  1  issue blocked this cycle.
reg_write  in  1  writeback valid.
dest  in  AW  writeback destination.
write_data  in  XLEN  writeback data.

Behaviour:
- Reset (rst=1 at clock edge): all NREG registers cleared to 0, all busy bits cleared. Reads return 0 the cycle after reset. reg_write and issue_valid are ignored while rst=1.
- Write: on a clock edge with reg_write=1, mem[dest] <= write_data. If ZERO_REG=1 and dest=0, the write is dropped. The write also clears busy[dest]; a write to a non-busy register is legal and leaves busy at 0.
- Read data, combinational, in priority order:
  - ZERO_REG=1 and src=0 -> 0.
  - BYPASS=1, reg_write=1 and dest=src (with ZERO_REG=1, dest nonzero) -> write_data.
  - Otherwise -> mem[src].
- Effective busy eff_busy[r]:
  - busy[r] & ~(BYPASS & reg_write & dest==r).
  - Forced 0 when ZERO_REG=1 and r=0.
- Busy outputs: readN_busy = eff_busy[srcN]. Both are 0 when issue_valid=0? No: they are valid regardless of issue_valid.
- Hazard:
  - hazard = issue_valid & (read1_busy | read2_busy | (issue_wr & eff_busy[issue_dest])).
  - Decode treats the src-busy terms as don't-care for unused operands by masking externally.
- Issue accepted when issue_valid & ~hazard & issue_wr: busy[issue_dest] <= 1 on that edge. With ZERO_REG=1 and issue_dest=0, no effect.
- Same-edge writeback clear and issue set on the same register: set wins, so busy stays 1. This is the new producer.
- BYPASS=0: read and busy see pre-edge state only, so a same-cycle writeback still reads stale data and raises hazard.
- Latency:
  - Reads are 0-cycle.
  - A write is visible via mem from the next cycle, or the same cycle via bypass.
  - A busy set is visible from the next cycle.
- No internal stall state: hazard is purely a function of current inputs and busy state.

Decomposition:
- Shared package rf_pkg:
  - default XLEN/NREG constants
  - REG_ZERO address constant
  - a helper function for the zero-register check
- Sub-module rf_scoreboard holds:
  - the NREG busy-bit vector
  - set/clear/priority logic
  - eff_busy lookup for three addresses (src1, src2, issue_dest)
- Data array, bypass muxes and the zero-register gate stay in reg_file_sb.

Test Plan:
1. Reset then read: rst high for 1 cycle, then src1=5, src2=31 -> read1=0, read2=0, both busy=0, hazard=0.
2. Write/read/bypass:
   - reg_write=1, dest=7, write_data=0xDEADBEEF with src1=7 in the same cycle -> read1=0xDEADBEEF same cycle (BYPASS=1).
   - Next cycle, with reg_write=0 -> still 0xDEADBEEF.
3. Zero register:
   - Write dest=0, data=0x1234 -> read of src=0 returns 0.
   - Issue issue_dest=0, issue_wr=1 -> no hazard next cycle and read1_busy=0 for src1=0.
4. RAW stall:
   - Issue dest=3, issue_wr=1 -> next cycle src1=3, issue_valid=1 gives read1_busy=1, hazard=1.
   - Writeback dest=3 data=0x55 in the same cycle -> hazard=0, read1=0x55.
5. Simultaneous clear/set: busy[4]=1; same edge reg_write dest=4 and accepted issue dest=4 -> busy[4]=1 afterwards, mem[4]=written value.
6. Reset mid-operation:
   - busy[9]=1, mem[9]=0xA5.
   - Assert rst with reg_write=1, dest=9, data=0xFF -> after edge, mem[9]=0 and busy[9]=0.
   - Rerun scenarios 2 and 4 with BYPASS=0, XLEN=64, NREG=16 -> stale reads and hazard held until the cycle after writeback.
